// File: rtl/rf_writeback_pkg.sv
// Shared configuration for the register-file writeback slice: default sizes and
// the one-hot destination decode used by the arbiter and the scoreboard.
package rf_writeback_pkg;

   localparam int unsigned RF_WB_REGNO     = 8;
   localparam int unsigned RF_WB_REGNO_LOG = 3;
   localparam int unsigned RF_WB_RW        = 16;
   localparam int unsigned RF_WB_LQ_DEPTH  = 4;

   // Decode is built at a fixed maximum width; callers cast down to their REGNO.
   localparam int unsigned RF_WB_MAX_LOG   = 6;
   localparam int unsigned RF_WB_MAX_REGNO = 1 << RF_WB_MAX_LOG;

   function automatic logic [RF_WB_MAX_REGNO-1:0] rf_wb_onehot(
      input logic [RF_WB_MAX_LOG-1:0] idx
   );
      logic [RF_WB_MAX_REGNO-1:0] vec;
      vec      = '0;
      vec[idx] = 1'b1;
      return vec;
   endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// Load-result queue: circular buffer with wrapping pointers and an occupancy
// count one bit wider than the pointers so full and empty are distinguishable.
module rf_wb_fifo #(
   parameter int unsigned Width = 19,
   parameter int unsigned Depth = 4,
   localparam int unsigned PtrW = $clog2(Depth),
   localparam int unsigned CntW = PtrW + 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_push,
   input  logic [Width-1:0] i_d,
   input  logic             i_pop,
   output logic [Width-1:0] o_d,
   output logic             o_empty,
   output logic [CntW-1:0]  o_count
);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             push_ok, pop_ok;

   // Guard against overflow/underflow so a misbehaving caller cannot corrupt order.
   assign push_ok = i_push && (count_q != CntW'(Depth));
   assign pop_ok  = i_pop && (count_q != '0);

   // Next-state pointers and occupancy; push+pop together leaves count unchanged.
   always_comb begin
      wr_ptr_d = push_ok ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
      rd_ptr_d = pop_ok ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
      count_d  = count_q;
      if (push_ok && !pop_ok) begin
         count_d = count_q + CntW'(1);
      end else if (!push_ok && pop_ok) begin
         count_d = count_q - CntW'(1);
      end
   end

   // Pointer and count state.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset; occupancy decides what is valid.
   always_ff @(posedge i_clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= i_d;
      end
   end

   assign o_d     = mem_q[rd_ptr_q];
   assign o_empty = (count_q == '0);
   assign o_count = count_q;

endmodule

// File: rtl/rf_writeback.sv
// Register-file write-side controller: arbitrates ALU results over load results
// (loads that lose are queued in order), drives a registered one-hot write port,
// and keeps a per-register pending scoreboard with a sticky protocol-error flag.
// Optional build macro RF_WB_R0_ZERO_EN: r0 is hardwired, writes to it are dropped
// and it is never marked pending.
module rf_writeback
   import rf_writeback_pkg::*;
#(
   parameter int unsigned REGNO     = RF_WB_REGNO,
   parameter int unsigned REGNO_LOG = RF_WB_REGNO_LOG,
   parameter int unsigned RW        = RF_WB_RW,
   parameter int unsigned LQ_DEPTH  = RF_WB_LQ_DEPTH
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_alu_valid,
   input  logic [REGNO_LOG-1:0] i_alu_reg,
   input  logic [RW-1:0]        i_alu_d,
   input  logic                 i_mem_valid,
   output logic                 o_mem_ready,
   input  logic [REGNO_LOG-1:0] i_mem_reg,
   input  logic [RW-1:0]        i_mem_d,
   input  logic                 i_issue_valid,
   input  logic [REGNO_LOG-1:0] i_issue_reg,
   output logic [REGNO-1:0]     o_rf_ie,
   output logic [RW-1:0]        o_rf_d,
   output logic [REGNO-1:0]     o_pending,
   output logic                 o_err
);

   localparam int unsigned EntW = REGNO_LOG + RW;
   localparam int unsigned CntW = $clog2(LQ_DEPTH) + 1;

   logic                 mem_fire;
   logic                 lq_push, lq_pop, lq_empty;
   logic [EntW-1:0]      lq_rd;
   logic [CntW-1:0]      lq_count;
   logic                 sel_valid;
   logic [REGNO_LOG-1:0] sel_reg;
   logic [RW-1:0]        sel_d;
   logic [REGNO-1:0]     rf_ie_q, rf_ie_d;
   logic [RW-1:0]        rf_d_q, rf_d_d;
   logic [REGNO-1:0]     pending_q, pending_d;
   logic [REGNO-1:0]     issue_set;
   logic                 err_q, err_d;

   // Ready looks only at registered occupancy, so a full queue refuses even when popping.
   assign o_mem_ready = (lq_count != CntW'(LQ_DEPTH));
   assign mem_fire    = i_mem_valid && o_mem_ready;

   rf_wb_fifo #(
      .Width (EntW),
      .Depth (LQ_DEPTH)
   ) u_lq (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (lq_push),
      .i_d     ({i_mem_reg, i_mem_d}),
      .i_pop   (lq_pop),
      .o_d     (lq_rd),
      .o_empty (lq_empty),
      .o_count (lq_count)
   );

   // Priority select: ALU, then oldest queued load, then a load straight through.
   always_comb begin
      sel_valid = 1'b0;
      sel_reg   = '0;
      sel_d     = '0;
      lq_pop    = 1'b0;
      lq_push   = 1'b0;
      if (i_alu_valid) begin
         sel_valid = 1'b1;
         sel_reg   = i_alu_reg;
         sel_d     = i_alu_d;
         lq_push   = mem_fire;
      end else if (!lq_empty) begin
         sel_valid          = 1'b1;
         {sel_reg, sel_d}   = lq_rd;
         lq_pop             = 1'b1;
         lq_push            = mem_fire;
      end else if (mem_fire) begin
         sel_valid = 1'b1;
         sel_reg   = i_mem_reg;
         sel_d     = i_mem_d;
      end
`ifdef RF_WB_R0_ZERO_EN
      // The slot is still consumed; only the register-file write is suppressed.
      if (sel_reg == '0) begin
         sel_valid = 1'b0;
      end
`endif
   end

   // Write port next state; data holds when nothing is written.
   always_comb begin
      rf_ie_d = sel_valid ? REGNO'(rf_wb_onehot(RF_WB_MAX_LOG'(sel_reg))) : '0;
      rf_d_d  = sel_valid ? sel_d : rf_d_q;
   end

   // Scoreboard: set on issue, clear on the cycle the write is presented; set wins.
   always_comb begin
      issue_set = i_issue_valid ? REGNO'(rf_wb_onehot(RF_WB_MAX_LOG'(i_issue_reg))) : '0;
`ifdef RF_WB_R0_ZERO_EN
      issue_set[0] = 1'b0;
`endif
      pending_d = (pending_q & ~rf_ie_q) | issue_set;
      err_d     = err_q
                  | (|(issue_set & pending_q & ~rf_ie_q))
                  | (|(rf_ie_q & ~pending_q));
   end

   // Registered outputs and scoreboard state.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rf_ie_q   <= '0;
         rf_d_q    <= '0;
         pending_q <= '0;
         err_q     <= 1'b0;
      end else begin
         rf_ie_q   <= rf_ie_d;
         rf_d_q    <= rf_d_d;
         pending_q <= pending_d;
         err_q     <= err_d;
      end
   end

   assign o_rf_ie   = rf_ie_q;
   assign o_rf_d    = rf_d_q;
   assign o_pending = pending_q;
   assign o_err     = err_q;

endmodule
